dual_port_ram_be_sync: RTL and testbench

Parametrised successor to the single-write-port synchronous dual-port RAM used by the AHB_VGA frame/text buffers. It provides two independent read/write ports with byte enables, a selectable read-during-write policy, an optional output pipeline register, and a post-reset clear sequencer. It sits between the AHB slave write path and the VGA pixel fetch path, and is also intended for other AHB peripherals that need shared storage.

---
 rtl/dual_port_ram_be_sync.sv | 167 ++++++++++++++++
 tb/tb_dual_port_ram_be_sync.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_be_sync.sv
// Dual-port synchronous RAM with byte-lane writes, selectable read-during-write
// behaviour, optional output register and a post-reset clear sequencer.
module dual_port_ram_be_sync #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 8,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             busy,
  input  logic                             en_a,
  input  logic                             we_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [DATA_WIDTH-1:0]            din_a,
  output logic [DATA_WIDTH-1:0]            dout_a,
  output logic                             rvalid_a,
  input  logic                             en_b,
  input  logic                             we_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            din_b,
  output logic [DATA_WIDTH-1:0]            dout_b,
  output logic                             rvalid_b,
  output logic                             collision
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BW    = BYTE_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    READY
  } state_t;

  localparam state_t START =
    state_t'((CLEAR_ON_RESET != 0) ? CLEAR : READY);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n;
  logic                  clr_we;

  logic                  acc_a, acc_b;
  logic                  wr_a, wr_b;
  logic [NB-1:0]         wl_a, wl_b;
  logic                  same;
  logic                  col_n;
  logic [DATA_WIDTH-1:0] post_a, post_b;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  logic [DATA_WIDTH-1:0] d1_a, d1_b;
  logic                  v1_a, v1_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= START;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clr_we  = 1'b0;
    unique case (state)
      IDLE:  state_n = START;
      CLEAR: begin
        clr_we = ~reset;
        cnt_n  = cnt + 1'b1;
        if (&cnt) state_n = READY;
      end
      READY: state_n = READY;
      default: state_n = START;
    endcase
  end

  assign busy  = (state != READY);
  assign acc_a = en_a & ~busy & ~reset;
  assign acc_b = en_b & ~busy & ~reset;
  assign wr_a  = acc_a & we_a;
  assign wr_b  = acc_b & we_b;
  assign wl_a  = {NB{wr_a}} & be_a;
  assign wl_b  = {NB{wr_b}} & be_b;
  assign same  = (addr_a == addr_b);
  assign col_n = same & |(wl_a & wl_b);

  // Post-write word at each port address; port A lanes applied last so A wins.
  always_comb begin
    post_a = mem[addr_a];
    post_b = mem[addr_b];
    for (int i = 0; i < NB; i++) begin
      if (wl_b[i]) begin
        post_b[i*BW +: BW] = din_b[i*BW +: BW];
        if (same) post_a[i*BW +: BW] = din_b[i*BW +: BW];
      end
      if (wl_a[i]) begin
        post_a[i*BW +: BW] = din_a[i*BW +: BW];
        if (same) post_b[i*BW +: BW] = din_a[i*BW +: BW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) mem[cnt] <= '0;
    if (|wl_b) mem[addr_b] <= post_b;
    if (|wl_a) mem[addr_a] <= post_a;
  end

  assign rd_a = (RDW_MODE != 0) ? post_a : mem[addr_a];
  assign rd_b = (RDW_MODE != 0) ? post_b : mem[addr_b];

  always_ff @(posedge clk) begin
    if (reset) begin
      d1_a      <= '0;
      d1_b      <= '0;
      v1_a      <= 1'b0;
      v1_b      <= 1'b0;
      collision <= 1'b0;
    end else begin
      v1_a      <= acc_a;
      v1_b      <= acc_b;
      collision <= col_n;
      if (acc_a) d1_a <= rd_a;
      if (acc_b) d1_b <= rd_b;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] d2_a, d2_b;
    logic                  v2_a, v2_b;

    always_ff @(posedge clk) begin
      if (reset) begin
        d2_a <= '0;
        d2_b <= '0;
        v2_a <= 1'b0;
        v2_b <= 1'b0;
      end else begin
        v2_a <= v1_a;
        v2_b <= v1_b;
        if (v1_a) d2_a <= d1_a;
        if (v1_b) d2_b <= d1_b;
      end
    end

    assign dout_a   = d2_a;
    assign dout_b   = d2_b;
    assign rvalid_a = v2_a;
    assign rvalid_b = v2_b;
  end else begin : g_noreg
    assign dout_a   = d1_a;
    assign dout_b   = d1_b;
    assign rvalid_a = v1_a;
    assign rvalid_b = v1_b;
  end

endmodule

// File: tb/tb_dual_port_ram_be_sync.sv
// Directed bench: u0 is read-first/no output reg, u1 is write-through/output reg,
// both 32-bit words with four byte lanes, sharing the same stimulus.
module tb_dual_port_ram_be_sync;

  logic        clk;
  logic        reset;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b;
  logic [5:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic        busy0, busy1;
  logic [31:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic        rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
  logic        collision0, collision1;

  logic [31:0] ref_mem [64];
  int          n_chk;
  int          n_fail;
  int          n;

  dual_port_ram_be_sync #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .BYTE_WIDTH(8),
    .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) u0 (
    .clk(clk), .reset(reset), .busy(busy0),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
    .din_a(din_a), .dout_a(dout_a0), .rvalid_a(rvalid_a0),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b),
    .din_b(din_b), .dout_b(dout_b0), .rvalid_b(rvalid_b0),
    .collision(collision0)
  );

  dual_port_ram_be_sync #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .BYTE_WIDTH(8),
    .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) u1 (
    .clk(clk), .reset(reset), .busy(busy1),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
    .din_a(din_a), .dout_a(dout_a1), .rvalid_a(rvalid_a1),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b),
    .din_b(din_b), .dout_b(dout_b1), .rvalid_b(rvalid_b1),
    .collision(collision1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en_a = 0; we_a = 0; be_a = 0;
    en_b = 0; we_b = 0; be_b = 0;
  endtask

  task automatic set_a(input logic w, input logic [3:0] be,
                       input logic [5:0] ad, input logic [31:0] d);
    en_a = 1; we_a = w; be_a = be; addr_a = ad; din_a = d;
  endtask

  task automatic set_b(input logic w, input logic [3:0] be,
                       input logic [5:0] ad, input logic [31:0] d);
    en_b = 1; we_b = w; be_b = be; addr_b = ad; din_b = d;
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("clr_busy1_done", busy1, 0);
  endtask

  task automatic sweep();
    int rv0a, rv0b, rv1a, rv1b;
    rv0a = 0; rv0b = 0; rv1a = 0; rv1b = 0;
    for (int k = 0; k <= 64; k++) begin
      idle();
      if (k < 64) begin
        set_a(0, 4'h0, 6'(k), 32'h0);
        set_b(0, 4'h0, 6'(k + 32), 32'h0);
      end
      tick();
      if (k < 64) begin
        chk("sw_a0", dout_a0, ref_mem[k]);
        chk("sw_b0", dout_b0, ref_mem[(k + 32) % 64]);
        rv0a += int'(rvalid_a0);
        rv0b += int'(rvalid_b0);
      end else begin
        chk("sw_end_rv_a0", rvalid_a0, 0);
      end
      if (k >= 1) begin
        chk("sw_a1", dout_a1, ref_mem[k - 1]);
        chk("sw_b1", dout_b1, ref_mem[(k + 31) % 64]);
        rv1a += int'(rvalid_a1);
        rv1b += int'(rvalid_b1);
      end
    end
    idle();
    chk("sw_rv_a0", rv0a, 64);
    chk("sw_rv_b0", rv0b, 64);
    chk("sw_rv_a1", rv1a, 64);
    chk("sw_rv_b1", rv1b, 64);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    addr_a = 0; addr_b = 0; din_a = 0; din_b = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    idle();
    reset = 1;
    repeat (3) tick();

    chk("rst_dout_a0", dout_a0, 0);
    chk("rst_dout_b0", dout_b0, 0);
    chk("rst_rv_a0", rvalid_a0, 0);
    chk("rst_rv_b0", rvalid_b0, 0);
    chk("rst_col0", collision0, 0);
    chk("rst_busy0", busy0, 1);
    chk("rst_dout_a1", dout_a1, 0);
    chk("rst_rv_b1", rvalid_b1, 0);
    chk("rst_col1", collision1, 0);
    chk("rst_busy1", busy1, 1);

    reset = 0;
    wait_clear(n);
    chk("clr_len_1", n, 64);

    // seed every word with ones, then prove a second reset clears them
    for (int i = 0; i < 64; i++) begin
      set_a(1, 4'hF, 6'(i), 32'hFFFF_FFFF);
      tick();
      if (i == 0) chk("first_acc_rv", rvalid_a0, 1);
    end
    idle();
    set_b(0, 4'h0, 6'd0, 32'h0);
    tick();
    idle();
    chk("seed_rd", dout_b0, 32'hFFFF_FFFF);

    reset = 1;
    tick();
    reset = 0;
    wait_clear(n);
    chk("clr_len_2", n, 64);
    sweep();

    // byte-enable merge
    set_a(1, 4'hF, 6'd5, 32'h1122_3344);
    tick();
    set_a(1, 4'h5, 6'd5, 32'hAABB_CCDD);
    tick();
    chk("be_a0_old", dout_a0, 32'h1122_3344);
    idle();
    set_b(0, 4'h0, 6'd5, 32'h0);
    tick();
    idle();
    chk("be_b0", dout_b0, 32'h11BB_33DD);
    chk("be_a1_new", dout_a1, 32'h11BB_33DD);
    chk("be_rv_b1_early", rvalid_b1, 0);
    tick();
    chk("be_b1", dout_b1, 32'h11BB_33DD);
    chk("be_rv_b1", rvalid_b1, 1);
    ref_mem[5] = 32'h11BB_33DD;

    // write/write conflict with overlapping lanes
    set_a(1, 4'h3, 6'd3, 32'hAAAA_AAAA);
    set_b(1, 4'h6, 6'd3, 32'hBBBB_BBBB);
    tick();
    idle();
    chk("col0", collision0, 1);
    chk("col1", collision1, 1);
    chk("col_a0_old", dout_a0, 32'h0);
    chk("col_b0_old", dout_b0, 32'h0);
    tick();
    chk("col0_drop", collision0, 0);
    chk("col1_drop", collision1, 0);
    chk("col_a1_new", dout_a1, 32'h00BB_AAAA);
    chk("col_b1_new", dout_b1, 32'h00BB_AAAA);
    ref_mem[3] = 32'h00BB_AAAA;

    // same address, disjoint lanes
    set_a(1, 4'h1, 6'd9, 32'h1111_1111);
    set_b(1, 4'h2, 6'd9, 32'h2222_2222);
    tick();
    idle();
    chk("nocol0", collision0, 0);
    ref_mem[9] = 32'h0000_2211;
    set_a(0, 4'h0, 6'd3, 32'h0);
    set_b(0, 4'h0, 6'd9, 32'h0);
    tick();
    idle();
    chk("rd3_a0", dout_a0, 32'h00BB_AAAA);
    chk("rd9_b0", dout_b0, 32'h0000_2211);

    // read-during-write, cross-port and same-port
    set_a(1, 4'hF, 6'd7, 32'h12);
    tick();
    idle();
    set_a(1, 4'hF, 6'd7, 32'h34);
    set_b(0, 4'h0, 6'd7, 32'h0);
    tick();
    idle();
    chk("rdw_b0", dout_b0, 32'h12);
    chk("rdw_a0", dout_a0, 32'h12);
    tick();
    chk("rdw_b1", dout_b1, 32'h34);
    chk("rdw_a1", dout_a1, 32'h34);
    ref_mem[7] = 32'h34;

    // write with no lanes behaves as a read
    set_a(1, 4'h0, 6'd7, 32'hFF);
    tick();
    idle();
    chk("be0_rd", dout_a0, 32'h34);
    chk("be0_rv", rvalid_a0, 1);

    sweep();

    // reset in the middle of a clear restarts it
    reset = 1;
    tick();
    reset = 0;
    repeat (20) tick();
    chk("mid_busy_pre", busy0, 1);
    reset = 1;
    tick();
    chk("mid_busy_rst", busy0, 1);
    reset = 0;
    repeat (5) tick();
    set_a(1, 4'hF, 6'd2, 32'hDEAD_BEEF);
    tick();
    idle();
    chk("busy_wr_rv0", rvalid_a0, 0);
    wait_clear(n);
    chk("clr_len_mid", n, 58);
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    set_a(0, 4'h0, 6'd2, 32'h0);
    tick();
    idle();
    chk("busy_wr_lost", dout_a0, 32'h0);
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
